// File: rtl/delay_tap_sequencer.sv
// Steps per-lane IODELAY tap values toward a software-requested target, one CE
// pulse at a time, with a shared reset-all path and a software readback word.
module delay_tap_sequencer #(
    parameter int LANES    = 8,
    parameter int TAP_W    = 5,
    parameter int STEP_GAP = 4
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    input  logic [31:0]      cmd_word,
    output logic [LANES-1:0] dly_ce,
    output logic             dly_inc,
    output logic             dly_rst,
    output logic             busy,
    output logic [31:0]      status_out
);

    localparam int GW = $clog2(STEP_GAP + 1);

    typedef enum logic [2:0] {IDLE, DECODE, STEP, GAP, RSTALL, DONE} state_t;

    state_t state, next_state;

    logic             arm_q;
    logic             cmd_det;
    logic [3:0]       lane_q;
    logic [TAP_W-1:0] target_q;
    logic             rstall_q;
    logic             err;
    logic [7:0]       done_cnt;
    logic [3:0]       last_lane;
    logic [TAP_W-1:0] cur_tap [LANES];
    logic [GW-1:0]    gap_cnt;

    logic             lane_ok;
    logic [TAP_W-1:0] lane_tap;
    logic [TAP_W-1:0] last_tap;
    logic             step_go;
    logic [LANES-1:0] ce_d;
    logic             inc_d;
    logic             rst_d;
    logic             unused_cmd;

    assign cmd_det    = cmd_word[31] != arm_q;
    assign lane_ok    = 32'(lane_q) < LANES;
    assign unused_cmd = ^cmd_word;

    always_comb begin
        lane_tap = '0;
        last_tap = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_q == 4'(i))
                lane_tap = cur_tap[i];
            if (last_lane == 4'(i))
                last_tap = cur_tap[i];
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // cur_tap is already updated on entry to STEP, so reaching the target there
    // finishes the command without spending a trailing GAP.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_det) next_state = DECODE;
            DECODE: begin
                if (rstall_q)                next_state = RSTALL;
                else if (!lane_ok)           next_state = DONE;
                else if (target_q == lane_tap) next_state = DONE;
                else                         next_state = STEP;
            end
            STEP:    next_state = (lane_tap == target_q) ? DONE : GAP;
            GAP: begin
                if (gap_cnt == GW'(STEP_GAP - 1))
                    next_state = (lane_tap != target_q) ? STEP : DONE;
            end
            RSTALL:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pulse outputs are decided from next_state so they appear registered in the
    // cycle the FSM occupies STEP or RSTALL.
    always_comb begin
        step_go = (next_state == STEP);
        rst_d   = (next_state == RSTALL);
        inc_d   = step_go ? (target_q > lane_tap) : dly_inc;
        ce_d    = '0;
        for (int unsigned i = 0; i < LANES; i++)
            if (lane_q == 4'(i))
                ce_d[i] = step_go;
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            arm_q     <= cmd_word[31];
            dly_ce    <= '0;
            dly_inc   <= 1'b0;
            dly_rst   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            done_cnt  <= '0;
            last_lane <= '0;
            lane_q    <= '0;
            target_q  <= '0;
            rstall_q  <= 1'b0;
            gap_cnt   <= '0;
            for (int unsigned i = 0; i < LANES; i++)
                cur_tap[i] <= '0;
        end else begin
            arm_q   <= cmd_word[31];
            dly_ce  <= ce_d;
            dly_inc <= inc_d;
            dly_rst <= rst_d;

            if (cmd_det && state == IDLE) begin
                lane_q   <= cmd_word[19:16];
                target_q <= cmd_word[TAP_W-1:0];
                rstall_q <= cmd_word[23];
                busy     <= 1'b1;
                err      <= 1'b0;
            end else if (cmd_det) begin
                err <= 1'b1;
            end

            if (state == DECODE && !rstall_q && !lane_ok)
                err <= 1'b1;

            for (int unsigned i = 0; i < LANES; i++) begin
                if (rst_d)
                    cur_tap[i] <= '0;
                else if (step_go && lane_q == 4'(i))
                    cur_tap[i] <= inc_d ? cur_tap[i] + TAP_W'(1) : cur_tap[i] - TAP_W'(1);
            end

            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;

            if (state == DONE) begin
                busy     <= 1'b0;
                done_cnt <= done_cnt + 8'd1;
                if (!err)
                    last_lane <= lane_q;
            end
        end
    end

    assign status_out = {busy, err, 6'b0, done_cnt, 4'b0, last_lane, 3'b0, 5'(last_tap)};

endmodule
